// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and pointer-width helper for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 32;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake bundle between a FIFO user (master) and the FIFO itself (slave).
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);

    logic                        w_en;
    logic [DATA_WIDTH-1:0]       data_in;
    logic                        r_en;
    logic                        err_clr;
    logic [DATA_WIDTH-1:0]       data_out;
    logic                        rd_valid;
    logic                        full;
    logic                        empty;
    logic                        almost_full;
    logic                        almost_empty;
    logic [ptr_width(DEPTH):0]   count;
    logic                        overflow;
    logic                        underflow;

    modport master (
        output w_en, data_in, r_en, err_clr,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, err_clr,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    localparam int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO control: pointers, occupancy, threshold flags, sticky errors
// and the standard / first-word-fall-through read path.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    param_sync_fifo_if.slave    bus
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dvalid;

    // Acceptance uses the registered flags, so a full FIFO can still pop and
    // an empty FIFO can still push in the same cycle.
    assign wr_acc = bus.w_en && !full_q && !rst;
    assign rd_acc = bus.r_en && !empty_q && !rst;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CW'(AF_THRESH));
            ae_q    <= (count_nxt <= CW'(AE_THRESH));
            // A new error event outranks a clear in the same cycle.
            if (bus.w_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (bus.r_en && empty_q) begin
                udf_q <= 1'b1;
            end else if (bus.err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            always_comb begin
                dout   = empty_q ? '0 : mem_rdata;
                dvalid = !empty_q;
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dvalid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem_rdata;
                    end
                end
            end

            always_comb begin
                dout   = dout_q;
                dvalid = dvalid_q;
            end
        end
    endgenerate

    assign bus.data_out     = dout;
    assign bus.rd_valid     = dvalid;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a standard-read and an FWFT instance at DEPTH=32.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(32)) bus_s ();
    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(32)) bus_f ();

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(32), .FWFT(0), .AF_THRESH(28), .AE_THRESH(4))
        u_std (.clk(clk), .rst(rst), .bus(bus_s));

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(32), .FWFT(1), .AF_THRESH(28), .AE_THRESH(4))
        u_fwft (.clk(clk), .rst(rst), .bus(bus_f));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] popped;
    logic       w, r, wacc, racc;
    logic [7:0] d;

    initial begin
        bus_s.w_en = 0; bus_s.r_en = 0; bus_s.err_clr = 0; bus_s.data_in = 0;
        bus_f.w_en = 0; bus_f.r_en = 0; bus_f.err_clr = 0; bus_f.data_in = 0;

        // Reset state
        rst = 1;
        tick(); tick();
        check("rst_count", 32'(bus_s.count), 0);
        check("rst_empty", 32'(bus_s.empty), 1);
        check("rst_ae", 32'(bus_s.almost_empty), 1);
        check("rst_full", 32'(bus_s.full), 0);
        check("rst_af", 32'(bus_s.almost_full), 0);
        check("rst_ovf", 32'(bus_s.overflow), 0);
        check("rst_udf", 32'(bus_s.underflow), 0);
        check("rst_valid", 32'(bus_s.rd_valid), 0);
        check("rst_dout", 32'(bus_s.data_out), 0);
        check("rst_f_valid", 32'(bus_f.rd_valid), 0);
        check("rst_f_dout", 32'(bus_f.data_out), 0);
        rst = 0;
        tick();

        // Fill 0x00..0x1F
        for (int i = 0; i < 32; i++) begin
            bus_s.w_en = 1; bus_s.data_in = 8'(i);
            tick();
            check("fill_count", 32'(bus_s.count), 32'(i + 1));
            check("fill_full", 32'(bus_s.full), 32'(i == 31));
            check("fill_af", 32'(bus_s.almost_full), 32'(i + 1 >= 28));
            check("fill_ae", 32'(bus_s.almost_empty), 32'(i + 1 <= 4));
            check("fill_empty", 32'(bus_s.empty), 0);
        end

        // Overflow on a full FIFO
        bus_s.data_in = 8'hFF;
        tick(); tick(); tick();
        check("ovf_set", 32'(bus_s.overflow), 1);
        check("ovf_count", 32'(bus_s.count), 32);
        bus_s.err_clr = 1;
        tick();
        check("ovf_set_wins", 32'(bus_s.overflow), 1);
        bus_s.w_en = 0;
        tick();
        check("ovf_clr", 32'(bus_s.overflow), 0);
        bus_s.err_clr = 0;

        // Full with simultaneous write and read
        bus_s.w_en = 1; bus_s.r_en = 1; bus_s.data_in = 8'hEE;
        tick();
        check("fullrw_count", 32'(bus_s.count), 31);
        check("fullrw_ovf", 32'(bus_s.overflow), 1);
        check("fullrw_valid", 32'(bus_s.rd_valid), 1);
        check("fullrw_dout", 32'(bus_s.data_out), 0);
        check("fullrw_full", 32'(bus_s.full), 0);
        bus_s.w_en = 0; bus_s.r_en = 0; bus_s.err_clr = 1;
        tick();
        bus_s.err_clr = 0;
        check("fullrw_ovf_clr", 32'(bus_s.overflow), 0);
        check("idle_valid", 32'(bus_s.rd_valid), 0);
        check("idle_hold", 32'(bus_s.data_out), 0);

        // Drain remaining 31 words in order
        for (int i = 1; i < 32; i++) begin
            bus_s.r_en = 1;
            tick();
            check("drain_dout", 32'(bus_s.data_out), 32'(i));
            check("drain_valid", 32'(bus_s.rd_valid), 1);
            check("drain_count", 32'(bus_s.count), 32'(31 - i));
            check("drain_empty", 32'(bus_s.empty), 32'(i == 31));
        end
        bus_s.r_en = 0;
        tick();
        check("post_valid", 32'(bus_s.rd_valid), 0);
        check("post_hold", 32'(bus_s.data_out), 32'h1F);

        // Empty with simultaneous write and read
        bus_s.w_en = 1; bus_s.r_en = 1; bus_s.data_in = 8'hA5;
        tick();
        check("udf_count", 32'(bus_s.count), 1);
        check("udf_set", 32'(bus_s.underflow), 1);
        check("udf_valid", 32'(bus_s.rd_valid), 0);
        check("udf_empty", 32'(bus_s.empty), 0);
        bus_s.w_en = 0;
        tick();
        check("udf_rd_dout", 32'(bus_s.data_out), 32'hA5);
        check("udf_rd_valid", 32'(bus_s.rd_valid), 1);
        check("udf_rd_empty", 32'(bus_s.empty), 1);
        bus_s.r_en = 0; bus_s.err_clr = 1;
        tick();
        bus_s.err_clr = 0;
        check("udf_clr", 32'(bus_s.underflow), 0);

        // FWFT instance
        check("f_empty0", 32'(bus_f.empty), 1);
        bus_f.w_en = 1; bus_f.data_in = 8'h3C;
        tick();
        check("f_empty", 32'(bus_f.empty), 0);
        check("f_valid", 32'(bus_f.rd_valid), 1);
        check("f_dout", 32'(bus_f.data_out), 32'h3C);
        bus_f.data_in = 8'h4D;
        tick();
        bus_f.w_en = 0;
        check("f_dout_hold", 32'(bus_f.data_out), 32'h3C);
        check("f_count2", 32'(bus_f.count), 2);
        bus_f.r_en = 1;
        tick();
        check("f_pop_dout", 32'(bus_f.data_out), 32'h4D);
        check("f_pop_count", 32'(bus_f.count), 1);
        tick();
        bus_f.r_en = 0;
        check("f_last_empty", 32'(bus_f.empty), 1);
        check("f_last_valid", 32'(bus_f.rd_valid), 0);

        // Random concurrent traffic around count 16, with pointer wrap
        for (int i = 0; i < 16; i++) begin
            bus_s.w_en = 1; bus_s.data_in = 8'(8'h40 + i);
            q.push_back(8'(8'h40 + i));
            tick();
        end
        bus_s.w_en = 0;
        check("rnd_pre_count", 32'(bus_s.count), 16);
        for (int i = 0; i < 100; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            wacc = w && (q.size() < 32);
            racc = r && (q.size() > 0);
            popped = 8'h00;
            if (racc) popped = q.pop_front();
            if (wacc) q.push_back(d);
            bus_s.w_en = w; bus_s.r_en = r; bus_s.data_in = d;
            tick();
            check("rnd_count", 32'(bus_s.count), 32'(q.size()));
            check("rnd_valid", 32'(bus_s.rd_valid), 32'(racc));
            if (racc) check("rnd_dout", 32'(bus_s.data_out), 32'(popped));
            check("rnd_af", 32'(bus_s.almost_full), 32'(q.size() >= 28));
            check("rnd_ae", 32'(bus_s.almost_empty), 32'(q.size() <= 4));
        end
        bus_s.w_en = 0; bus_s.r_en = 0;

        // Reset mid-operation at count 20
        rst = 1;
        tick();
        rst = 0;
        bus_s.r_en = 1;
        tick();
        bus_s.r_en = 0;
        check("mid_udf", 32'(bus_s.underflow), 1);
        for (int i = 0; i < 20; i++) begin
            bus_s.w_en = 1; bus_s.data_in = 8'(i + 8'h80);
            tick();
        end
        check("mid_count20", 32'(bus_s.count), 20);
        rst = 1; bus_s.data_in = 8'h77;
        tick();
        check("mid_rst_count", 32'(bus_s.count), 0);
        check("mid_rst_empty", 32'(bus_s.empty), 1);
        check("mid_rst_ae", 32'(bus_s.almost_empty), 1);
        check("mid_rst_af", 32'(bus_s.almost_full), 0);
        check("mid_rst_full", 32'(bus_s.full), 0);
        check("mid_rst_udf", 32'(bus_s.underflow), 0);
        check("mid_rst_ovf", 32'(bus_s.overflow), 0);
        check("mid_rst_valid", 32'(bus_s.rd_valid), 0);
        check("mid_rst_dout", 32'(bus_s.data_out), 0);
        rst = 0; bus_s.w_en = 0;
        tick();
        check("mid_post_count", 32'(bus_s.count), 0);
        check("mid_post_empty", 32'(bus_s.empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter DEPTH, default 32, entries; power of two, >= 4.
REQ-003 Parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-004 Parameter AF_THRESH, default DEPTH-4, almost_full level; range 1..DEPTH.
REQ-005 Parameter AE_THRESH, default 4, almost_empty level; range 0..DEPTH-1.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous and active-high.
REQ-008 w_en  in  1  write request.
REQ-009 data_in  in  DATA_WIDTH  write data.
REQ-010 r_en  in  1  read request (pop in FWFT mode).
REQ-011 err_clr  in  1  clears sticky error flags.
REQ-012 data_out  out  DATA_WIDTH  read data.
REQ-013 rd_valid  out  1  data_out qualifier.
REQ-014 full, empty  out  1 each  occupancy == DEPTH / == 0.
REQ-015 almost_full, almost_empty  out  1 each  threshold flags.
REQ-016 count  out  log2(DEPTH)+1  current occupancy.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Write accepted iff w_en && !full; read accepted iff r_en && !empty, both evaluated on the registered flags of the current cycle.
REQ-019 Accepted write stores data_in at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-020 Accepted read advances rd_ptr modulo DEPTH.
REQ-021 count: +1 write only, -1 read only, unchanged when both or neither are accepted.
REQ-022 full, empty, almost_full (count >= AF_THRESH), almost_empty (count <= AE_THRESH) are registered and reflect count after the same edge.
REQ-023 Standard mode: data_out loads mem[rd_ptr] on the edge of an accepted read; rd_valid high exactly the following cycle; data_out holds otherwise.
REQ-024 FWFT mode: data_out = mem[rd_ptr] whenever !empty; rd_valid = !empty; an accepted read exposes the next word on the following cycle.
REQ-025 Write-to-visible latency: a word written into an empty FIFO deasserts empty one cycle later; in FWFT mode it is valid on data_out in that same cycle.
REQ-026 Full with w_en && r_en: read accepted, write rejected, overflow set; the next cycle shows count = DEPTH-1.
REQ-027 Empty with w_en && r_en: write accepted, read rejected, underflow set; the next cycle shows count = 1.
REQ-028 overflow sets on w_en && full; underflow sets on r_en && empty; each remains high until err_clr; set wins over a simultaneous err_clr.
REQ-029 Rejected operations do not modify pointers, count or memory.

Reset
REQ-030 While rst is high: pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, rd_valid = 0, data_out = 0.
REQ-031 Reset mid-operation discards all contents; w_en and r_en are ignored during the rst cycle; memory array is not reset.

Structure
REQ-032 Shared package fifo_pkg holds pointer-width computation (clog2) and default DEPTH/DATA_WIDTH constants.
REQ-033 Storage is a sub-module sync_fifo_mem: one write port, asynchronous read port, no reset.
REQ-034 Control (pointers, count, flags, errors) resides in param_sync_fifo.

Verification
REQ-035 DEPTH=32, FWFT=0: write 0x00..0x1F, then read 32 -> full after 32nd write, data_out 0x00..0x1F in order, rd_valid one cycle after each read, then empty = 1.
REQ-036 Full FIFO, 3 cycles of w_en -> overflow = 1, count stays 32, contents unchanged; err_clr pulse -> overflow = 0.
REQ-037 Empty FIFO, simultaneous w_en/r_en with data 0xA5 -> count = 1, underflow = 1, and the next read returns 0xA5.
REQ-038 FWFT=1: single write 0x3C into empty FIFO -> next cycle empty = 0, rd_valid = 1, data_out = 0x3C without r_en.
REQ-039 Pointer wrap: 100 cycles of random concurrent traffic at count around 16 -> scoreboard matches; almost_full/almost_empty track count at 28/4.
REQ-040 rst asserted at count = 20 with w_en high -> next cycle count = 0, empty = 1, all flags cleared.
